// File: rtl/cde_reset_sequencer.sv
// cde_reset_sequencer
//   Holds NUM_STAGES downstream active-low resets asserted until the PLL is
//   locked and no software reset is requested. It then releases them one at a
//   time, bit 0 first, with STAGE_DLY cycles between releases. Loss of lock or
//   a software request re-asserts every stage together.
//
// Ports
//   clk           system clock, all logic on posedge
//   reset_n       asynchronous active-low reset
//   pll_lock      asynchronous, 1 = clock stable
//   soft_rst_req  asynchronous level, 1 = reset all stages
//   rst_n_out     sequenced active-low resets, bit 0 released first
//   seq_done      1 = all stages released
//   busy          1 = sequence not complete
//   lock_lost     one-cycle pulse when a release/run is aborted by lock loss
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_ASSERT  | all stages held in reset, counting qualified hold cycles
// ST_RELEASE | stage 0 released, releasing the rest every STAGE_DLY cycles
// ST_RUN     | all stages released
module cde_reset_sequencer #(
  parameter int DEPTH      = 2,
  parameter int NUM_STAGES = 3,
  parameter int HOLD_DLY   = 8,
  parameter int STAGE_DLY  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic                  busy,
  output logic                  lock_lost
);

  localparam int STG_W = $clog2(NUM_STAGES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_DLY - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [STG_W-1:0] STG_LAST   = STG_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [DEPTH-1:0]      lock_sync_q;
  logic [DEPTH-1:0]      req_sync_q;
  logic                  lock_s;
  logic                  req_s;
  logic                  qual;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STG_W-1:0]      stg_q, stg_d;
  logic [NUM_STAGES-1:0] rst_n_out_q, rst_n_out_d;
  logic                  seq_done_q, seq_done_d;
  logic                  busy_q, busy_d;
  logic                  lock_lost_q, lock_lost_d;

  assign lock_s = lock_sync_q[DEPTH-1];
  assign req_s  = req_sync_q[DEPTH-1];
  assign qual   = lock_s & ~req_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stg_d       = stg_q;
    rst_n_out_d = rst_n_out_q;
    lock_lost_d = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        rst_n_out_d = '0;
        if (!qual) begin
          cnt_d = '0;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d          = '0;
          stg_d          = STG_W'(1);
          rst_n_out_d[0] = 1'b1;
          state_d        = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
        end
      end

      ST_RELEASE, ST_RUN: begin
        // Abort wins over any release due on the same edge.
        if (!qual) begin
          state_d     = ST_ASSERT;
          rst_n_out_d = '0;
          cnt_d       = '0;
          stg_d       = '0;
          lock_lost_d = ~lock_s;
        end else if (state_q == ST_RELEASE) begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d = '0;
            stg_d = stg_q + 1'b1;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (stg_q == STG_W'(i)) rst_n_out_d[i] = 1'b1;
            end
            if (stg_q == STG_LAST) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_ASSERT;
        rst_n_out_d = '0;
        cnt_d       = '0;
        stg_d       = '0;
      end
    endcase

    seq_done_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= '0;
      req_sync_q  <= '0;
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      stg_q       <= '0;
      rst_n_out_q <= '0;
      seq_done_q  <= 1'b0;
      busy_q      <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[DEPTH-2:0], pll_lock};
      req_sync_q  <= {req_sync_q[DEPTH-2:0], soft_rst_req};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stg_q       <= stg_d;
      rst_n_out_q <= rst_n_out_d;
      seq_done_q  <= seq_done_d;
      busy_q      <= busy_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign rst_n_out = rst_n_out_q;
  assign seq_done  = seq_done_q;
  assign busy      = busy_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_cde_reset_sequencer.sv
`timescale 1ns/1ps
// Three sequencer configurations share one set of inputs. A behavioural model
// per configuration predicts outputs from the run length of qualified samples;
// expectations go into a queue at each posedge and a negedge monitor pops and
// compares. Directed phases also check spec timing against constant formulas.
module tb_cde_reset_sequencer;

  localparam int NCFG = 3;
  localparam int P_D [NCFG] = '{2, 3, 3};
  localparam int P_N [NCFG] = '{3, 1, 3};
  localparam int P_H [NCFG] = '{8, 1, 1};
  localparam int P_S [NCFG] = '{4, 1, 1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pll_lock = 1'b1;
  logic soft_rst_req = 1'b0;

  logic [2:0] rno0, rno2;
  logic       rno1;
  logic       sd0, sd1, sd2, bz0, bz1, bz2, ll0, ll1, ll2;
  logic [2:0] rno [NCFG];
  logic       sd [NCFG];
  logic       bz [NCFG];
  logic       ll [NCFG];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cde_reset_sequencer #(.DEPTH(2), .NUM_STAGES(3), .HOLD_DLY(8), .STAGE_DLY(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
    .rst_n_out(rno0), .seq_done(sd0), .busy(bz0), .lock_lost(ll0));

  cde_reset_sequencer #(.DEPTH(3), .NUM_STAGES(1), .HOLD_DLY(1), .STAGE_DLY(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
    .rst_n_out(rno1), .seq_done(sd1), .busy(bz1), .lock_lost(ll1));

  cde_reset_sequencer #(.DEPTH(3), .NUM_STAGES(3), .HOLD_DLY(1), .STAGE_DLY(1), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
    .rst_n_out(rno2), .seq_done(sd2), .busy(bz2), .lock_lost(ll2));

  assign rno[0] = rno0;
  assign rno[1] = {2'b00, rno1};
  assign rno[2] = rno2;
  assign sd[0] = sd0;
  assign sd[1] = sd1;
  assign sd[2] = sd2;
  assign bz[0] = bz0;
  assign bz[1] = bz1;
  assign bz[2] = bz2;
  assign ll[0] = ll0;
  assign ll[1] = ll1;
  assign ll[2] = ll2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected stage vector j edges into a sequence (edge 1 = first edge that
  // samples the qualifying inputs): stage i rises at edge D + H + i*S.
  function automatic logic [2:0] exp_rst(input int k, input int j);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < P_N[k]; i++)
      if (j >= P_D[k] + P_H[k] + i * P_S[k]) r[i] = 1'b1;
    return r;
  endfunction

  // Scoreboard model: FSM at edge e sees the qualify sample from edge e-D.
  // After R consecutive qualified evaluations, released = min(N, 1+(R-H)/S).
  for (genvar k = 0; k < NCFG; k++) begin : g_model
    localparam int D = P_D[k];
    localparam int N = P_N[k];
    localparam int H = P_H[k];
    localparam int S = P_S[k];

    bit         qual_hist[$];
    bit         lock_hist[$];
    logic [5:0] sb[$];
    int         run_len;
    int         rel_prev;
    int         rel;
    bit         qv, lv, lost;
    logic [2:0] r;
    logic [5:0] e_q;

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        qual_hist.delete();
        lock_hist.delete();
        for (int i = 0; i < D; i++) begin
          qual_hist.push_back(1'b0);
          lock_hist.push_back(1'b0);
        end
        run_len  = 0;
        rel_prev = 0;
        sb.delete();
      end else begin
        qv = qual_hist.pop_front();
        lv = lock_hist.pop_front();
        qual_hist.push_back(pll_lock & ~soft_rst_req);
        lock_hist.push_back(pll_lock);
        if (qv) begin
          if (run_len < 1000000) run_len++;
        end else begin
          run_len = 0;
        end
        if (run_len >= H) begin
          rel = 1 + (run_len - H) / S;
          if (rel > N) rel = N;
        end else begin
          rel = 0;
        end
        lost = !lv && (rel_prev > 0);
        r = '0;
        for (int i = 0; i < N; i++) if (i < rel) r[i] = 1'b1;
        sb.push_back({r, rel == N, rel != N, lost});
        rel_prev = rel;
      end
    end

    always @(negedge clk) begin
      if (sb.size() > 0) begin
        e_q = sb.pop_front();
        chk($sformatf("cfg%0d_rst_done_busy_lost", k),
            {58'd0, rno[k], sd[k], bz[k], ll[k]}, {58'd0, e_q});
      end else if (!reset_n) begin
        chk($sformatf("cfg%0d_in_reset", k),
            {58'd0, rno[k], sd[k], bz[k], ll[k]}, 64'b000_0_1_0);
      end
    end
  end

  task automatic seq_check(input string tag, input int j0, input int j1, input bit all_cfg);
    for (int j = j0; j <= j1; j++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NCFG; k++) begin
        if (k == 0 || all_cfg) begin
          chk($sformatf("%s_cfg%0d_rst_j%0d", tag, k, j), rno[k], exp_rst(k, j));
          chk($sformatf("%s_cfg%0d_done_j%0d", tag, k, j), sd[k],
              j >= P_D[k] + P_H[k] + (P_N[k] - 1) * P_S[k]);
        end
      end
    end
  endtask

  // Called at a negedge; the pulse lies entirely between clock edges.
  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++)
      chk($sformatf("async_rst_cfg%0d", k), {58'd0, rno[k], sd[k], bz[k], ll[k]}, 64'b000_0_1_0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    pll_lock = 1'b1;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    seq_check("pwrup", 1, 22, 1'b1);

    // lock held low for 50 cycles, then relock
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (50) @(negedge clk);
    chk("lock_low_no_release", {55'd0, rno[0], rno[1], rno[2]}, 64'd0);
    pll_lock = 1'b1;
    seq_check("relock", 1, 22, 1'b1);

    // soft reset request while running
    @(negedge clk);
    soft_rst_req = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("req_assert_j%0d", j), rno[0], (j >= 3) ? 3'b000 : 3'b111);
      chk($sformatf("req_no_lost_j%0d", j), ll[0], 1'b0);
    end
    repeat (3) @(negedge clk);
    soft_rst_req = 1'b0;
    seq_check("req_restart", 1, 22, 1'b1);

    // lock lost between stage 1 and stage 2 release
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    pll_lock = 1'b1;
    seq_check("abort_pre", 1, 14, 1'b0);
    @(negedge clk);
    pll_lock = 1'b0;
    for (int j = 15; j <= 18; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort_rst_j%0d", j), rno[0], (j >= 17) ? 3'b000 : 3'b011);
      chk($sformatf("abort_lost_j%0d", j), ll[0], j == 17);
    end

    // one-cycle lock glitch while hold counter is at 5
    repeat (2) @(negedge clk);
    pll_lock = 1'b1;
    seq_check("glitch_pre", 1, 5, 1'b0);
    @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    for (int j = 7; j <= 18; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("glitch_hold_j%0d", j), rno[0], (j >= 16) ? 3'b001 : 3'b000);
    end

    // asynchronous reset in the middle of RELEASE
    @(negedge clk);
    reset_pulse();
    seq_check("rst_restart", 1, 22, 1'b1);

    // randomized input levels and occasional resets
    for (int it = 0; it < 150; it++) begin
      @(negedge clk);
      pll_lock     = ($urandom_range(0, 5) != 0);
      soft_rst_req = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 24) == 0) reset_pulse();
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
